// File: rtl/wave_rx_buf_ctrl_if.sv
// Bundle of the receive byte stream, sample-RAM write port and per-channel
// frame handshake between the UDP receive engine, sample RAM and consumer.
interface wave_rx_buf_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              rx_en;
    logic [7:0]        rx_data;
    logic              rx_pkt_done;
    logic [15:0]       rx_byte_num;
    logic [1:0]        rx_source;
    logic              ram_we;
    logic [ADDR_W+1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [1:0]        frame_vld;
    logic [1:0]        frame_bank;
    logic [1:0]        frame_ack;
    logic [15:0]       drop_cnt;
    logic [15:0]       err_cnt;
    logic              busy;

    modport master (
        output rx_en, rx_data, rx_pkt_done, rx_byte_num, rx_source, frame_ack,
        input  ram_we, ram_waddr, ram_wdata, frame_vld, frame_bank,
               drop_cnt, err_cnt, busy
    );

    modport slave (
        input  rx_en, rx_data, rx_pkt_done, rx_byte_num, rx_source, frame_ack,
        output ram_we, ram_waddr, ram_wdata, frame_vld, frame_bank,
               drop_cnt, err_cnt, busy
    );
endinterface

// File: rtl/wave_rx_buf_ctrl.sv
// Steers tagged payload bytes into per-channel ping-pong banks of the sample
// RAM, tracks full banks for the consumer and rolls back mis-sized packets.
module wave_rx_buf_ctrl #(
    parameter int FRAME_LEN = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    wave_rx_buf_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t            state, state_nxt;
    logic              ch_q;
    logic [ADDR_W-1:0] pkt_start;
    logic [16:0]       pkt_cnt;
    logic              frame_in_pkt;
    logic [ADDR_W-1:0] wptr [2];
    logic [1:0]        wr_bank;
    logic [1:0]        rd_bank;
    logic [1:0]        bank_full [2];
    logic [15:0]       drop_cnt;
    logic [15:0]       err_cnt;

    logic              in_idle;
    logic              src_good;
    logic              cur_ch;
    logic              cur_bank;
    logic [ADDR_W-1:0] cur_wptr;
    logic              accept;
    logic              bad_start;
    logic              writable;
    logic              do_write;
    logic              do_drop;
    logic              completes;
    logic [16:0]       total;
    logic              done_check;
    logic              mismatch;
    logic              frame_seen;
    logic [ADDR_W-1:0] start_ptr;
    logic              rollback;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A packet whose first byte is also its last never leaves IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rx_en && !bus.rx_pkt_done)
                    state_nxt = src_good ? RECV : DISCARD;
            end
            RECV, DISCARD: begin
                if (bus.rx_pkt_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_idle    = (state == IDLE);
        src_good   = (bus.rx_source == 2'b01) || (bus.rx_source == 2'b10);
        cur_ch     = in_idle ? bus.rx_source[1] : ch_q;
        cur_bank   = wr_bank[cur_ch];
        cur_wptr   = wptr[cur_ch];
        accept     = bus.rx_en && ((in_idle && src_good) || (state == RECV));
        bad_start  = in_idle && bus.rx_en && !src_good;
        writable   = !bank_full[cur_ch][cur_bank];
        do_write   = accept && writable;
        do_drop    = accept && !writable;
        completes  = do_write && (cur_wptr == ADDR_W'(FRAME_LEN - 1));
        total      = (in_idle ? 17'd0 : pkt_cnt) + {16'd0, accept};
        done_check = bus.rx_pkt_done &&
                     ((in_idle && bus.rx_en && src_good) || (state == RECV));
        mismatch   = done_check && (total != {1'b0, bus.rx_byte_num});
        frame_seen = (!in_idle && frame_in_pkt) || completes;
        start_ptr  = in_idle ? cur_wptr : pkt_start;
        rollback   = mismatch && !frame_seen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q          <= 1'b0;
            pkt_start     <= '0;
            pkt_cnt       <= '0;
            frame_in_pkt  <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                wptr[c]      <= '0;
                bank_full[c] <= '0;
            end
            wr_bank       <= '0;
            rd_bank       <= '0;
            drop_cnt      <= '0;
            err_cnt       <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_waddr <= '0;
            bus.ram_wdata <= '0;
        end else begin
            bus.ram_we <= do_write;
            if (accept) begin
                pkt_cnt      <= total;
                frame_in_pkt <= frame_seen;
                if (in_idle) begin
                    ch_q      <= cur_ch;
                    pkt_start <= cur_wptr;
                end
            end
            // Ack releases the read bank; a completion can only hit the other one.
            for (int c = 0; c < 2; c++) begin
                if (bus.frame_ack[c] && bank_full[c][rd_bank[c]]) begin
                    bank_full[c][rd_bank[c]] <= 1'b0;
                    rd_bank[c]               <= ~rd_bank[c];
                end
            end
            if (do_write) begin
                bus.ram_waddr <= {cur_ch, cur_bank, cur_wptr};
                bus.ram_wdata <= bus.rx_data;
                if (completes) begin
                    bank_full[cur_ch][cur_bank] <= 1'b1;
                    wptr[cur_ch]                <= '0;
                    wr_bank[cur_ch]             <= ~cur_bank;
                end else begin
                    wptr[cur_ch] <= cur_wptr + ADDR_W'(1);
                end
            end
            if (rollback) wptr[cur_ch] <= start_ptr;
            if (do_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            if ((bad_start || mismatch) && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end

    always_comb begin
        bus.frame_vld = '0;
        for (int c = 0; c < 2; c++) bus.frame_vld[c] = bank_full[c][rd_bank[c]];
    end

    assign bus.frame_bank = rd_bank;
    assign bus.drop_cnt   = drop_cnt;
    assign bus.err_cnt    = err_cnt;
    assign bus.busy       = (state != IDLE) || bus.rx_en;
endmodule

// File: tb/tb_wave_rx_buf_ctrl.sv
// Self-checking bench: packet-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wave_rx_buf_ctrl;
    localparam int FRAME_LEN = 64;
    localparam int ADDR_W    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wave_rx_buf_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    wave_rx_buf_ctrl #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en      = 1'b0;
    bit rand_ack_en = 1'b0;
    int last_waddr  = 0;

    // Reference model state: per-channel write position, bank flags, read bank
    int m_wptr [2];
    int m_wb   [2];
    int m_rd   [2];
    bit m_full [2][2];
    bit in_pkt, good, m_completed;
    int m_ch, m_start, m_cnt;
    int m_drop, m_err;
    bit exp_we;
    int exp_addr, exp_data;
    bit ack_ok [2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_wptr[c] = 0; m_wb[c] = 0; m_rd[c] = 0;
                m_full[c][0] = 1'b0; m_full[c][1] = 1'b0;
            end
            in_pkt = 1'b0; good = 1'b0; m_completed = 1'b0;
            m_ch = 0; m_start = 0; m_cnt = 0;
            m_drop = 0; m_err = 0;
            exp_we = 1'b0; exp_addr = 0; exp_data = 0;
        end else begin
            for (int c = 0; c < 2; c++) ack_ok[c] = bus.frame_ack[c] && m_full[c][m_rd[c]];
            exp_we = 1'b0;
            if (bus.rx_en) begin
                if (!in_pkt) begin
                    in_pkt = 1'b1;
                    good   = (bus.rx_source == 2'b01) || (bus.rx_source == 2'b10);
                    if (good) begin
                        m_ch = (bus.rx_source == 2'b10) ? 1 : 0;
                        m_start = m_wptr[m_ch];
                        m_cnt = 0;
                        m_completed = 1'b0;
                    end else if (m_err < 65535) begin
                        m_err++;
                    end
                end
                if (good) begin
                    m_cnt++;
                    if (!m_full[m_ch][m_wb[m_ch]]) begin
                        exp_we   = 1'b1;
                        exp_addr = m_ch * 2 * FRAME_LEN + m_wb[m_ch] * FRAME_LEN + m_wptr[m_ch];
                        exp_data = int'(bus.rx_data);
                        m_wptr[m_ch]++;
                        if (m_wptr[m_ch] == FRAME_LEN) begin
                            m_full[m_ch][m_wb[m_ch]] = 1'b1;
                            m_wptr[m_ch] = 0;
                            m_wb[m_ch]   = 1 - m_wb[m_ch];
                            m_completed  = 1'b1;
                        end
                    end else if (m_drop < 65535) begin
                        m_drop++;
                    end
                end
            end
            if (bus.rx_pkt_done && in_pkt) begin
                if (good && (m_cnt != int'(bus.rx_byte_num))) begin
                    if (m_err < 65535) m_err++;
                    if (!m_completed) m_wptr[m_ch] = m_start;
                end
                in_pkt = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                if (ack_ok[c]) begin
                    m_full[c][m_rd[c]] = 1'b0;
                    m_rd[c] = 1 - m_rd[c];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("ram_we", bus.ram_we, exp_we);
            if (exp_we) begin
                checkOutput("ram_waddr", bus.ram_waddr, exp_addr);
                checkOutput("ram_wdata", bus.ram_wdata, exp_data);
            end
            checkOutput("frame_vld", bus.frame_vld, {m_full[1][m_rd[1]], m_full[0][m_rd[0]]});
            checkOutput("frame_bank", bus.frame_bank, {m_rd[1] == 1, m_rd[0] == 1});
            checkOutput("drop_cnt", bus.drop_cnt, m_drop);
            checkOutput("err_cnt", bus.err_cnt, m_err);
            checkOutput("busy", bus.busy, in_pkt || bus.rx_en);
            if (bus.ram_we) last_waddr = int'(bus.ram_waddr);
        end
    end

    task automatic tick();
        if (rand_ack_en)
            bus.frame_ack = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
        @(posedge clk);
        #2;
    endtask

    task automatic checkAt();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] src, input int len, input int num,
                                 input int gap, input bit rand_data);
        for (int i = 0; i < len; i++) begin
            bus.rx_en       = 1'b1;
            bus.rx_source   = src;
            bus.rx_data     = rand_data ? 8'($urandom) : 8'(i);
            bus.rx_pkt_done = (i == len - 1);
            bus.rx_byte_num = 16'(num);
            tick();
        end
        bus.rx_en       = 1'b0;
        bus.rx_pkt_done = 1'b0;
        bus.rx_source   = 2'b00;
        repeat (gap) tick();
    endtask

    task automatic doReset(input int n);
        rst             = 1'b1;
        bus.rx_en       = 1'b0;
        bus.rx_pkt_done = 1'b0;
        bus.frame_ack   = 2'b00;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.rx_en = 1'b0; bus.rx_data = 8'h00; bus.rx_pkt_done = 1'b0;
        bus.rx_byte_num = 16'd0; bus.rx_source = 2'b00; bus.frame_ack = 2'b00;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        doReset(2);
        checkAt();
        checkOutput("reset_ram_we", bus.ram_we, 0);
        checkOutput("reset_waddr", bus.ram_waddr, 0);
        checkOutput("reset_wdata", bus.ram_wdata, 0);
        checkOutput("reset_vld", bus.frame_vld, 0);
        checkOutput("reset_bank", bus.frame_bank, 0);
        checkOutput("reset_counts", {bus.drop_cnt, bus.err_cnt}, 0);
        checkOutput("reset_busy", bus.busy, 0);

        // 16-byte A packet lands at ch0 bank0 offsets 0..15
        applyStimulus(2'b01, 16, 16, 2, 1'b0);
        checkAt();
        checkOutput("t1_vld", bus.frame_vld, 2'b00);
        checkOutput("t1_last_addr", last_waddr, 8'h0F);

        // Four more packets: bank0 completes, remainder goes to bank1
        repeat (4) applyStimulus(2'b01, 16, 16, 1, 1'b1);
        checkAt();
        checkOutput("t2_vld", bus.frame_vld, 2'b01);
        checkOutput("t2_bank", bus.frame_bank, 2'b00);
        checkOutput("t2_last_addr", last_waddr, 8'h4F);

        // Fill bank1, then a 10-byte packet has nowhere to go
        repeat (3) applyStimulus(2'b01, 16, 16, 1, 1'b1);
        applyStimulus(2'b01, 10, 10, 2, 1'b1);
        checkAt();
        checkOutput("t3_drop", bus.drop_cnt, 16'd10);
        checkOutput("t3_last_addr", last_waddr, 8'h7F);
        checkOutput("t3_err", bus.err_cnt, 16'd0);
        bus.frame_ack = 2'b01;
        tick();
        bus.frame_ack = 2'b00;
        checkAt();
        checkOutput("t3_ack1_vld", bus.frame_vld, 2'b01);
        checkOutput("t3_ack1_bank", bus.frame_bank, 2'b01);
        bus.frame_ack = 2'b01;
        tick();
        bus.frame_ack = 2'b00;
        checkAt();
        checkOutput("t3_ack2_vld", bus.frame_vld, 2'b00);

        // B: good 5 bytes, then short packet rolls back to offset 5
        applyStimulus(2'b10, 5, 5, 1, 1'b1);
        applyStimulus(2'b10, 8, 12, 1, 1'b1);
        checkAt();
        checkOutput("t4_err", bus.err_cnt, 16'd1);
        applyStimulus(2'b10, 4, 4, 2, 1'b1);
        checkAt();
        checkOutput("t4_last_addr", last_waddr, 8'h88);

        // Bad source: nothing written, one error
        applyStimulus(2'b11, 6, 6, 2, 1'b1);
        checkAt();
        checkOutput("t5_err", bus.err_cnt, 16'd2);
        checkOutput("t5_last_addr", last_waddr, 8'h88);

        // Reset in the middle of a packet
        for (int i = 0; i < 7; i++) begin
            bus.rx_en = 1'b1; bus.rx_source = 2'b01; bus.rx_data = 8'($urandom);
            bus.rx_pkt_done = 1'b0; bus.rx_byte_num = 16'd20;
            tick();
        end
        doReset(1);
        checkAt();
        checkOutput("t6_ram_we", bus.ram_we, 0);
        checkOutput("t6_waddr", bus.ram_waddr, 0);
        checkOutput("t6_vld", bus.frame_vld, 0);
        checkOutput("t6_counts", {bus.drop_cnt, bus.err_cnt}, 0);
        checkOutput("t6_busy", bus.busy, 0);
        applyStimulus(2'b01, 3, 3, 2, 1'b1);
        checkAt();
        checkOutput("t6_last_addr", last_waddr, 8'h02);

        // Randomized traffic with random consumer acks
        rand_ack_en = 1'b1;
        for (int p = 0; p < 80; p++) begin
            int r, len, num;
            logic [1:0] src;
            r   = $urandom_range(0, 9);
            src = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : ((r % 2) == 0) ? 2'b01 : 2'b10;
            len = $urandom_range(1, 40);
            num = len;
            if ($urandom_range(0, 4) == 0) num = len + $urandom_range(1, 3);
            else if ($urandom_range(0, 6) == 0) num = len - 1;
            applyStimulus(src, len, num, $urandom_range(0, 3), 1'b1);
        end
        rand_ack_en   = 1'b0;
        bus.frame_ack = 2'b00;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wave_rx_buf_ctrl.md
Name: wave_rx_buf_ctrl

Overview:
- Receive-side scheduler between the UDP receive engine and the waveform sample RAM.
- Takes the per-byte payload stream tagged by source (A/B) and steers each channel into its own pair of ping-pong banks.
- Assembles fixed-length frames across packets and hands completed banks to the display/processing consumer with a valid/ack handshake.
- Discards bytes when no bank is free and rolls back packets whose byte count mismatches.

Parameters:
- FRAME_LEN, 1024: payload bytes per frame, which is one bank.
- ADDR_W, 10: bank offset width; FRAME_LEN must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock (receive byte clock).
- rst  in  1  synchronous reset, active-high.
- rx_en  in  1  payload byte strobe, one per byte.
- rx_data  in  8  payload byte.
- rx_pkt_done  in  1  packet end pulse; coincides with the last byte's rx_en.
- rx_byte_num  in  16  payload length of the finished packet; valid with rx_pkt_done.
- rx_source  in  2  01 = channel A, 10 = channel B; valid while rx_en.
- ram_we  out  1  sample RAM write enable.
- ram_waddr  out  ADDR_W+2  {ch, bank, offset}; ch 0 = A, 1 = B.
- ram_wdata  out  8  write data.
- frame_vld  out  2  per channel: a completed bank is waiting.
- frame_bank  out  2  per channel: bank index of the oldest completed bank.
- frame_ack  in  2  per channel: 1-cycle pulse, consumer releases frame_bank.
- drop_cnt  out  16  bytes discarded because no bank was free; saturating.
- err_cnt  out  16  bad-source packets plus length-mismatch packets; saturating.
- busy  out  1  high from first byte of a packet through its done cycle.

Behaviour:
- Reset: all outputs 0. States cleared to IDLE. Per-channel wr_bank = 0 and wptr = 0. All bank_full bits 0. rd_bank = 0.
- Packet FSM:
  - IDLE: rx_en with rx_source 01/10 → RECV; latch channel and pkt_start = wptr; process the byte.
  - IDLE: rx_en with rx_source 00/11 → DISCARD; err_cnt +1.
  - RECV: each rx_en byte is written if a bank is writable. rx_pkt_done → IDLE, same cycle.
  - DISCARD: bytes are ignored and not counted in drop_cnt. rx_pkt_done → IDLE.
  - A single-byte packet (rx_en and rx_pkt_done in the same cycle from IDLE) is fully processed and returns to IDLE.
- Byte write, latency 1:
  - A byte accepted at edge N gives ram_we=1 in cycle N+1, with ram_waddr = {ch, wr_bank, wptr} and ram_wdata = byte; then wptr increments.
  - A bank is writable when bank_full[ch][wr_bank] = 0. Otherwise the byte is dropped: drop_cnt +1, no write, wptr held.
- Frame completion:
  - Writing offset FRAME_LEN-1 sets bank_full[ch][wr_bank], sets wptr = 0 and toggles wr_bank, all at the same edge.
  - frame_vld[ch] is high in cycle N+1, coincident with the last write.
  - If the new wr_bank is still full, later bytes drop until it is acked.
- Consumer handshake:
  - frame_vld[ch] = bank_full[ch][rd_bank[ch]]; frame_bank[ch] = rd_bank[ch].
  - frame_ack[ch] while frame_vld[ch] clears that bit and toggles rd_bank. It takes effect at the next edge; if the other bank is full, vld stays high with the new bank.
  - frame_ack with vld low is ignored.
  - An ack and a completion on the same channel in one cycle are both applied; they target different banks by construction.
- Length check at rx_pkt_done:
  - Count accepted plus dropped bytes of the packet, including the done-cycle byte, and compare with rx_byte_num.
  - On mismatch: err_cnt +1. If no frame completed during the packet, wptr is restored to pkt_start; otherwise no rollback.
  - If the packet straddled a frame boundary, the completed bank stands.
- Counters saturate at 16'hFFFF. Both count values update at most once per cycle each.
- rst in any state aborts the packet and clears everything, including bank_full; any pending frame is lost.

Test Plan:
- Reset, then one A packet of 16 bytes (0x00..0x0F) with rx_byte_num=16 → 16 writes at offsets 0..15, ch0 bank0; data matches; each ram_we is 1 cycle after its rx_en; frame_vld=00.
- With FRAME_LEN=64, send 5 A packets of 16 bytes → frame_vld[0]=1 on the 64th write with frame_bank[0]=0; the remaining 16 bytes go to bank1 offsets 0..15.
- Fill both A banks with no ack, then send a 10-byte A packet → no writes, drop_cnt=10. Pulse frame_ack[0] → frame_bank[0] flips to 1 and vld stays 1. A second ack → vld=0.
- 8-byte B packet with rx_byte_num=12 → err_cnt=1; next B packet is written starting at the previous pkt_start offset.
- Packet with rx_source=11 → no writes, err_cnt +1, busy high through the done cycle. Assert rst mid-packet → all outputs 0 next cycle; the next packet writes from offset 0, bank0.
